frame_burst_scheduler: RTL and testbench

// - Burst-level scheduler sharing the processing input FIFO between two slave sources (slv0, slv1).
// - Grants one source for a fixed burst of BURST_LEN beats, forwards data, mode and proc value to the FIFO.
// - After the burst it waits for the master-complete pulse, then re-arbitrates round-robin.
// - Sits between the slave front-ends and the image-processing FIFO / master engine.

---
 rtl/frame_burst_scheduler.sv | 146 ++++++++++++++
 tb/tb_frame_burst_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_burst_scheduler.sv
// Burst-level round-robin scheduler that shares the image-processing FIFO between two slave sources.
// Optional idle abort in XFER is compiled in with `define ARB_TIMEOUT_EN.
module frame_burst_scheduler #(
    parameter int DW        = 32,
    parameter int PVW       = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     slv0_mode,
    input  logic [DW-1:0]  slv0_data,
    input  logic           slv0_data_valid,
    input  logic [PVW-1:0] slv0_proc_val,
    output logic           slv0_ready,
    input  logic [1:0]     slv1_mode,
    input  logic [DW-1:0]  slv1_data,
    input  logic           slv1_data_valid,
    input  logic [PVW-1:0] slv1_proc_val,
    output logic           slv1_ready,
    input  logic           fifo_full,
    output logic           fifo_wr_en,
    output logic [DW-1:0]  fifo_wdata,
    output logic [1:0]     fifo_mode,
    output logic [PVW-1:0] fifo_proc_val,
    output logic           fifo_src,
    input  logic           mstr_cmplt,
    output logic           busy,
    output logic           timeout_err
);

    // One counter width serves both the beat count and the idle count.
    localparam int CNT_MAX = (BURST_LEN > TIMEOUT) ? BURST_LEN : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, WAIT_CMPLT} state_t;

    state_t           state;
    logic             owner;
    logic             prio;
    logic [CNT_W-1:0] beat_cnt;

    logic             req0, req1;
    logic             acc0, acc1, accept;
    logic             to_hit;

    logic             vld_p1;
    logic [DW-1:0]    data_p1;
    logic [PVW-1:0]   pv_p1;
    logic             src_p1;

    assign req0 = |slv0_mode;
    assign req1 = |slv1_mode;

    assign slv0_ready = (state == XFER) && !owner && !fifo_full;
    assign slv1_ready = (state == XFER) &&  owner && !fifo_full;

    assign acc0   = slv0_ready && slv0_data_valid;
    assign acc1   = slv1_ready && slv1_data_valid;
    assign accept = acc0 || acc1;

    assign busy          = (state != IDLE);
    assign fifo_wr_en    = vld_p1;
    assign fifo_wdata    = data_p1;
    assign fifo_proc_val = pv_p1;
    assign fifo_src      = src_p1;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;
    logic             to_err_p1;

    assign to_hit = (state == XFER) && !accept && !fifo_full
                    && (idle_cnt == CNT_W'(TIMEOUT - 1));
    assign timeout_err = to_err_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            to_err_p1 <= 1'b0;
        end else begin
            to_err_p1 <= to_hit;
            if (state != XFER || accept || fifo_full || to_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            prio      <= 1'b0;
            beat_cnt  <= '0;
            fifo_mode <= 2'b00;
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            pv_p1     <= '0;
            src_p1    <= 1'b0;
        end else begin
            // accept -> p1: one-cycle registered write toward the FIFO
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= acc1 ? slv1_data : slv0_data;
                pv_p1   <= acc1 ? slv1_proc_val : slv0_proc_val;
                src_p1  <= owner;
            end

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= (req0 && req1) ? prio : req1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    fifo_mode <= owner ? slv1_mode : slv0_mode;
                    beat_cnt  <= '0;
                    state     <= XFER;
                end
                XFER: begin
                    if (to_hit) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == CNT_W'(BURST_LEN - 1))
                            state <= WAIT_CMPLT;
                    end
                end
                WAIT_CMPLT: begin
                    if (mstr_cmplt) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_burst_scheduler.sv
// Directed bench for frame_burst_scheduler with BURST_LEN=4, TIMEOUT=8.
// Timeout scenario follows whether ARB_TIMEOUT_EN is defined for the build.
module tb_frame_burst_scheduler;

    localparam int DW = 32;
    localparam int PVW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     slv0_mode = 2'b00, slv1_mode = 2'b00;
    logic [DW-1:0]  slv0_data = '0, slv1_data = '0;
    logic           slv0_data_valid = 1'b0, slv1_data_valid = 1'b0;
    logic [PVW-1:0] slv0_proc_val = '0, slv1_proc_val = '0;
    logic           slv0_ready, slv1_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_wdata;
    logic [1:0]     fifo_mode;
    logic [PVW-1:0] fifo_proc_val;
    logic           fifo_src;
    logic           mstr_cmplt = 1'b0;
    logic           busy;
    logic           timeout_err;

    frame_burst_scheduler #(.DW(DW), .PVW(PVW), .BURST_LEN(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .slv0_mode(slv0_mode), .slv0_data(slv0_data), .slv0_data_valid(slv0_data_valid),
        .slv0_proc_val(slv0_proc_val), .slv0_ready(slv0_ready),
        .slv1_mode(slv1_mode), .slv1_data(slv1_data), .slv1_data_valid(slv1_data_valid),
        .slv1_proc_val(slv1_proc_val), .slv1_ready(slv1_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .fifo_mode(fifo_mode), .fifo_proc_val(fifo_proc_val), .fifo_src(fifo_src),
        .mstr_cmplt(mstr_cmplt), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_data[$];
    logic [1:0]  q_mode[$];
    logic [7:0]  q_pv[$];
    logic        q_src[$];
    int          rd_idx = 0;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            q_data.push_back(fifo_wdata);
            q_mode.push_back(fifo_mode);
            q_pv.push_back(fifo_proc_val);
            q_src.push_back(fifo_src);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv_of(input logic [31:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction

    function automatic logic rdy_of(input bit s);
        return s ? slv1_ready : slv0_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input bit s, input bit v, input logic [31:0] d);
        if (s) begin
            slv1_data_valid = v; slv1_data = d; slv1_proc_val = pv_of(d);
        end else begin
            slv0_data_valid = v; slv0_data = d; slv0_proc_val = pv_of(d);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mstr_cmplt = 1'b0; fifo_full = 1'b0;
        slv0_mode = 2'b00; slv1_mode = 2'b00;
        set_src(1'b0, 1'b0, 32'h0);
        set_src(1'b1, 1'b0, 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        rd_idx = q_data.size();
    endtask

    task automatic pulse_cmplt();
        mstr_cmplt = 1'b1;
        step();
        mstr_cmplt = 1'b0;
    endtask

    // Offer n beats base..base+n-1 from source s; optional 3-cycle fifo_full after beat full_after.
    task automatic drive_beats(input bit s, input logic [31:0] base, input int n, input int full_after);
        int  i = 0;
        int  guard = 0;
        bit  other_seen = 1'b0;
        logic rdy;
        set_src(s, 1'b1, base);
        while (i < n && guard < 100) begin
            @(negedge clk);
            rdy = rdy_of(s);
            if (rdy_of(!s)) other_seen = 1'b1;
            step();
            guard++;
            if (rdy) begin
                i++;
                if (i == n) set_src(s, 1'b0, 32'h0);
                else        set_src(s, 1'b1, base + 32'(i));
                if (i == full_after) begin
                    fifo_full = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("bp_ready_low", 32'(rdy_of(s)), 32'd0);
                        step();
                    end
                    fifo_full = 1'b0;
                end
            end
        end
        set_src(s, 1'b0, 32'h0);
        check("beats_accepted", 32'(i), 32'(n));
        check("other_ready_low", 32'(other_seen), 32'd0);
    endtask

    task automatic expect_writes(input string tag, input int n, input bit s,
                                 input logic [1:0] mode, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if (rd_idx >= q_data.size()) begin
                check({tag, "_write_count"}, 32'(q_data.size()), 32'(rd_idx + 1));
            end else begin
                check({tag, "_data"}, q_data[rd_idx], base + 32'(i));
                check({tag, "_pv"},   32'(q_pv[rd_idx]), 32'(pv_of(base + 32'(i))));
                check({tag, "_src"},  32'(q_src[rd_idx]), 32'(s));
                check({tag, "_mode"}, 32'(q_mode[rd_idx]), 32'(mode));
                rd_idx++;
            end
        end
        check({tag, "_no_extra"}, 32'(q_data.size()), 32'(rd_idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ready_seen;
        int wr_before;

        // Reset state
        apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_ready0", 32'(slv0_ready), 32'd0);
        check("rst_mode", 32'(fifo_mode), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // Single source burst
        apply_reset();
        slv0_mode = 2'b01;
        drive_beats(1'b0, 32'hA0, 4, -1);
        slv0_mode = 2'b00;
        repeat (2) step();
        expect_writes("single", 4, 1'b0, 2'b01, 32'hA0);
        check("single_wait_busy", 32'(busy), 32'd1);
        check("single_wait_ready", 32'(slv0_ready), 32'd0);
        pulse_cmplt();
        check("single_busy_fall", 32'(busy), 32'd0);

        // Both requesting, hold in WAIT_CMPLT, round-robin
        apply_reset();
        slv0_mode = 2'b01; slv1_mode = 2'b10;
        drive_beats(1'b0, 32'hB0, 4, -1);
        ready_seen = 1'b0;
        wr_before = q_data.size();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (slv0_ready || slv1_ready) ready_seen = 1'b1;
            step();
        end
        check("hold_no_ready", 32'(ready_seen), 32'd0);
        expect_writes("rr_first", 4, 1'b0, 2'b01, 32'hB0);
        check("hold_busy", 32'(busy), 32'd1);
        pulse_cmplt();
        check("rr_idle_busy", 32'(busy), 32'd0);
        check("rr_idle_ready1", 32'(slv1_ready), 32'd0);
        step();
        check("rr_grant_busy", 32'(busy), 32'd1);
        check("rr_grant_ready1", 32'(slv1_ready), 32'd0);
        step();
        check("rr_xfer_ready1", 32'(slv1_ready), 32'd1);
        check("rr_xfer_ready0", 32'(slv0_ready), 32'd0);
        drive_beats(1'b1, 32'hC0, 4, -1);
        repeat (2) step();
        expect_writes("rr_second", 4, 1'b1, 2'b10, 32'hC0);
        pulse_cmplt();
        drive_beats(1'b0, 32'hD0, 4, -1);
        slv0_mode = 2'b00; slv1_mode = 2'b00;
        repeat (2) step();
        expect_writes("rr_third", 4, 1'b0, 2'b01, 32'hD0);
        pulse_cmplt();

        // Backpressure after beat 2
        apply_reset();
        slv0_mode = 2'b01;
        drive_beats(1'b0, 32'hE0, 4, 2);
        slv0_mode = 2'b00;
        repeat (2) step();
        expect_writes("bp", 4, 1'b0, 2'b01, 32'hE0);
        pulse_cmplt();

        // Reset mid-burst, then a full burst
        apply_reset();
        slv0_mode = 2'b01;
        drive_beats(1'b0, 32'hF0, 2, -1);
        rst_n = 1'b0;
        step();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("midrst_wdata", fifo_wdata, 32'd0);
        check("midrst_mode", 32'(fifo_mode), 32'd0);
        check("midrst_ready0", 32'(slv0_ready), 32'd0);
        rst_n = 1'b1;
        rd_idx = q_data.size();
        drive_beats(1'b0, 32'h100, 4, -1);
        slv0_mode = 2'b00;
        repeat (2) step();
        expect_writes("after_rst", 4, 1'b0, 2'b01, 32'h100);
        pulse_cmplt();

        // Stalled owner: timeout abort or indefinite wait
        apply_reset();
        slv0_mode = 2'b01; slv1_mode = 2'b10;
`ifdef ARB_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            bit busy_at_pulse = 1'b1;
            bit r1 = 1'b0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk);
                if (timeout_err) begin seen = 1'b1; busy_at_pulse = busy; end
            end
            check("to_pulse_seen", 32'(seen), 32'd1);
            check("to_busy_drop", 32'(busy_at_pulse), 32'd0);
            @(negedge clk);
            check("to_pulse_single", 32'(timeout_err), 32'd0);
            for (int k = 0; k < 5 && !r1; k++) begin
                @(negedge clk);
                if (slv1_ready) r1 = 1'b1;
            end
            check("to_slv1_granted", 32'(r1), 32'd1);
        end
`else
        begin
            bit dropped = 1'b0;
            bit te = 1'b0;
            repeat (3) step();
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (!busy) dropped = 1'b1;
                if (timeout_err) te = 1'b1;
            end
            check("noto_busy_held", 32'(dropped), 32'd0);
            check("noto_no_err", 32'(te), 32'd0);
            check("noto_slv0_owner", 32'(slv0_ready), 32'd1);
        end
`endif
        check("final_write_total", 32'(q_data.size()), 32'(rd_idx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
